// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and width helpers.
package seq_divider_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } div_state_t;

  // Iteration counter width able to hold 0..w
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, select.
module seq_divider_div_step #(
  parameter int unsigned l = 16
) (
  input  logic [l:0]   rem,
  input  logic         msb,
  input  logic [l-1:0] divisor,
  output logic [l:0]   rem_next,
  output logic         q_bit
);

  logic [l+1:0] shifted;
  logic [l+1:0] trial;

  // One extra bit of headroom so the borrow of the trial subtraction is visible
  assign shifted  = {rem, msb};
  assign trial    = shifted - {2'b00, divisor};
  assign q_bit    = ~trial[l+1];
  assign rem_next = q_bit ? trial[l:0] : shifted[l:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/busy/done handshake and signed/unsigned modes.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned l = DIV_WIDTH
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic         SIGNED,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [l-1:0] Q,
  output logic [l-1:0] R,
  output logic         DIV0
);

  localparam int unsigned CW = cnt_width(l);

  div_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [l:0]    rem, rem_n;
  logic [l-1:0]  dvd, dvd_n;
  logic [l-1:0]  dvs, dvs_n;
  logic [l-1:0]  a_lat, a_lat_n;
  logic          neg_q, neg_q_n;
  logic          neg_r, neg_r_n;
  logic          zero_div, zero_div_n;
  logic          busy_n, done_n, div0_n;
  logic [l-1:0]  q_n, r_n;

  logic [l-1:0]  a_mag, b_mag;
  logic [l:0]    step_rem;
  logic          step_q;

  // Magnitudes; -2^(l-1) maps to 2^(l-1) read as unsigned
  assign a_mag = (SIGNED && A[l-1]) ? (~A + l'(1)) : A;
  assign b_mag = (SIGNED && B[l-1]) ? (~B + l'(1)) : B;

  seq_divider_div_step #(.l(l)) u_step (
    .rem      (rem),
    .msb      (dvd[l-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      a_lat    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      DIV0     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      dvd      <= dvd_n;
      dvs      <= dvs_n;
      a_lat    <= a_lat_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      zero_div <= zero_div_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      Q        <= q_n;
      R        <= r_n;
      DIV0     <= div0_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    dvd_n      = dvd;
    dvs_n      = dvs;
    a_lat_n    = a_lat;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    zero_div_n = zero_div;
    busy_n     = BUSY;
    done_n     = 1'b0;
    q_n        = Q;
    r_n        = R;
    div0_n     = DIV0;

    unique case (state)
      IDLE: begin
        if (START) begin
          state_n = LOAD;
          busy_n  = 1'b1;
        end
      end
      LOAD: begin
        a_lat_n    = A;
        zero_div_n = (B == '0);
        neg_q_n    = SIGNED & (A[l-1] ^ B[l-1]);
        neg_r_n    = SIGNED & A[l-1];
        dvd_n      = a_mag;
        dvs_n      = b_mag;
        rem_n      = '0;
        cnt_n      = '0;
        state_n    = CALC;
      end
      CALC: begin
        // Quotient bits shift into the vacated low end of the dividend register
        rem_n = step_rem;
        dvd_n = {dvd[l-2:0], step_q};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(l - 1)) state_n = FIX;
      end
      FIX: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        if (zero_div) begin
          q_n    = '1;
          r_n    = a_lat;
          div0_n = 1'b1;
        end else begin
          q_n    = neg_q ? (~dvd + l'(1)) : dvd;
          r_n    = neg_r ? (~rem[l-1:0] + l'(1)) : rem[l-1:0];
          div0_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
